// File: rtl/sdram_pkg.sv
// ============================================================================
// sdram_pkg : shared types and default widths for the SDRAM request queue
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sdram_pkg;

    localparam int SDRAM_DEPTH   = 8;
    localparam int SDRAM_ADDR_W  = 22;
    localparam int SDRAM_DATA_W  = 16;
    localparam int SDRAM_TIMEOUT = 4096;

    typedef struct packed {
        logic                    we;
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] data;
    } sdram_cmd_t;

    typedef enum logic [0:0] {
        Q_IDLE = 1'b0,
        Q_WAIT = 1'b1
    } q_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_cmd_fifo.sv
// ============================================================================
// sdram_cmd_fifo : register-based synchronous FIFO of sdram_cmd_t
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sdram_cmd_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = SDRAM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  sdram_cmd_t               push_cmd,
    input  logic                     pop,
    output sdram_cmd_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    sdram_cmd_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_cmd;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_req_queue.sv
// ============================================================================
// sdram_req_queue : client command queue feeding sdram_controller one request
//                   at a time on its level req/ack interface
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int DEPTH   = SDRAM_DEPTH,
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int DATA_W  = SDRAM_DATA_W,
    parameter int TIMEOUT = SDRAM_TIMEOUT
) (
    input  logic                      iclk,
    input  logic                      ireset_n,
    input  logic                      icmd_valid,
    input  logic                      icmd_we,
    input  logic [ADDR_W-1:0]         icmd_addr,
    input  logic [DATA_W-1:0]         icmd_wdata,
    output logic                      ocmd_ready,
    output logic                      ord_valid,
    output logic [DATA_W-1:0]         ord_data,
    output logic [$clog2(DEPTH):0]    olevel,
    output logic                      obusy,
    output logic                      oerr_timeout,
    output logic                      oerr_ack,
    output logic                      owrite_req,
    output logic [ADDR_W-1:0]         owrite_address,
    output logic [DATA_W-1:0]         owrite_data,
    output logic                      oread_req,
    output logic [ADDR_W-1:0]         oread_address,
    input  logic                      iwrite_ack,
    input  logic                      iread_ack,
    input  logic [DATA_W-1:0]         iread_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    q_state_t      state;
    q_state_t      state_next;
    sdram_cmd_t    in_cmd;
    sdram_cmd_t    head_cmd;
    logic          full;
    logic          empty;
    logic          pop;
    logic          ack_match;
    logic          ack_bad;
    logic          req_we;
    logic [TW-1:0] wait_cnt;

    assign in_cmd     = sdram_cmd_t'{we: icmd_we, addr: icmd_addr, data: icmd_wdata};
    assign ocmd_ready = !full;
    assign obusy      = (olevel != '0) || (state == Q_WAIT);

    sdram_cmd_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (iclk),
        .rst_n    (ireset_n),
        .push     (icmd_valid),
        .push_cmd (in_cmd),
        .pop      (pop),
        .head     (head_cmd),
        .full     (full),
        .empty    (empty),
        .level    (olevel)
    );

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state <= Q_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ack_match  = 1'b0;
        ack_bad    = 1'b0;
        case (state)
            Q_IDLE: begin
                ack_bad = iwrite_ack || iread_ack;
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = Q_WAIT;
                end
            end
            Q_WAIT: begin
                ack_match = req_we ? iwrite_ack : iread_ack;
                ack_bad   = req_we ? iread_ack  : iwrite_ack;
                if (ack_match) begin
                    state_next = Q_IDLE;
                end
            end
            default: state_next = Q_IDLE;
        endcase
    end

    // The req drops on the ack edge so the controller's following IDLE
    // cycle never sees a stale request.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            owrite_req     <= 1'b0;
            oread_req      <= 1'b0;
            owrite_address <= '0;
            oread_address  <= '0;
            owrite_data    <= '0;
            req_we         <= 1'b0;
            wait_cnt       <= '0;
            ord_valid      <= 1'b0;
            ord_data       <= '0;
            oerr_timeout   <= 1'b0;
            oerr_ack       <= 1'b0;
        end else begin
            ord_valid <= 1'b0;
            if (ack_bad) begin
                oerr_ack <= 1'b1;
            end
            if (pop) begin
                req_we         <= head_cmd.we;
                owrite_req     <= head_cmd.we;
                oread_req      <= !head_cmd.we;
                owrite_address <= head_cmd.addr;
                oread_address  <= head_cmd.addr;
                owrite_data    <= head_cmd.data;
                wait_cnt       <= '0;
            end else if (state == Q_WAIT) begin
                if (ack_match) begin
                    owrite_req <= 1'b0;
                    oread_req  <= 1'b0;
                    if (!req_we) begin
                        ord_valid <= 1'b1;
                        ord_data  <= iread_data;
                    end
                end else if (wait_cnt != TW'(TIMEOUT - 1)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == TW'(TIMEOUT - 2)) begin
                        oerr_timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: queue-based reference model, stub controller,
// directed scenarios with literal expectations plus a randomized phase.
`timescale 1ns/1ps
`default_nettype none

module tb_sdram_req_queue;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 22;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 4096;

    logic                   iclk = 1'b0;
    logic                   ireset_n = 1'b0;
    logic                   icmd_valid = 1'b0;
    logic                   icmd_we = 1'b0;
    logic [ADDR_W-1:0]      icmd_addr = '0;
    logic [DATA_W-1:0]      icmd_wdata = '0;
    logic                   ocmd_ready;
    logic                   ord_valid;
    logic [DATA_W-1:0]      ord_data;
    logic [$clog2(DEPTH):0] olevel;
    logic                   obusy;
    logic                   oerr_timeout;
    logic                   oerr_ack;
    logic                   owrite_req;
    logic [ADDR_W-1:0]      owrite_address;
    logic [DATA_W-1:0]      owrite_data;
    logic                   oread_req;
    logic [ADDR_W-1:0]      oread_address;
    logic                   iwrite_ack = 1'b0;
    logic                   iread_ack = 1'b0;
    logic [DATA_W-1:0]      iread_data = '0;

    always #5 iclk = ~iclk;

    sdram_req_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .iclk(iclk), .ireset_n(ireset_n),
        .icmd_valid(icmd_valid), .icmd_we(icmd_we), .icmd_addr(icmd_addr), .icmd_wdata(icmd_wdata),
        .ocmd_ready(ocmd_ready), .ord_valid(ord_valid), .ord_data(ord_data), .olevel(olevel),
        .obusy(obusy), .oerr_timeout(oerr_timeout), .oerr_ack(oerr_ack),
        .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
        .oread_req(oread_req), .oread_address(oread_address),
        .iwrite_ack(iwrite_ack), .iread_ack(iread_ack), .iread_data(iread_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              we;
        bit [ADDR_W-1:0] addr;
        bit [DATA_W-1:0] data;
    } mcmd_t;

    mcmd_t           mq[$];
    mcmd_t           mcur;
    mcmd_t           mnew;
    bit              mout = 0;
    int              mwaited = 0;
    bit              m_rdv = 0;
    bit [DATA_W-1:0] m_rdd = '0;
    bit              m_to = 0;
    bit              m_ea = 0;
    bit              m_take;
    bit              m_acc;

    always @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            mq.delete();
            mout = 0; mwaited = 0; m_rdv = 0; m_rdd = '0; m_to = 0; m_ea = 0;
        end else begin
            m_take = !mout && (mq.size() != 0);
            m_acc  = icmd_valid && (mq.size() < DEPTH);
            mnew.we = icmd_we; mnew.addr = icmd_addr; mnew.data = icmd_wdata;
            m_rdv = 0;
            if (mout) begin
                if (mcur.we ? iread_ack : iwrite_ack) m_ea = 1;
                if (mcur.we ? iwrite_ack : iread_ack) begin
                    if (!mcur.we) begin
                        m_rdv = 1;
                        m_rdd = iread_data;
                    end
                    mout = 0;
                end else begin
                    mwaited++;
                    if (mwaited >= TIMEOUT) m_to = 1;
                end
            end else if (iwrite_ack || iread_ack) begin
                m_ea = 1;
            end
            if (m_take) begin
                mcur    = mq.pop_front();
                mout    = 1;
                mwaited = 1;
            end
            if (m_acc) mq.push_back(mnew);
        end
    end

    always @(negedge iclk) begin
        chk("ready", ocmd_ready, mq.size() < DEPTH);
        chk("level", olevel, mq.size());
        chk("busy", obusy, (mq.size() != 0) || mout);
        chk("write_req", owrite_req, mout && mcur.we);
        chk("read_req", oread_req, mout && !mcur.we);
        if (mout && mcur.we) begin
            chk("write_addr", owrite_address, mcur.addr);
            chk("write_data", owrite_data, mcur.data);
        end
        if (mout && !mcur.we) chk("read_addr", oread_address, mcur.addr);
        chk("rd_valid", ord_valid, m_rdv);
        chk("rd_data", ord_data, m_rdd);
        chk("err_timeout", oerr_timeout, m_to);
        chk("err_ack", oerr_ack, m_ea);
    end

    // ---------------- stub controller ----------------
    int              hi_cnt = 0;
    int              ack_lat = 0;
    bit              rand_lat = 0;
    bit              rand_data = 0;
    bit              inj_wack = 0;
    logic [DATA_W-1:0] rd_word = '0;

    always @(negedge iclk) begin
        #2;
        if (owrite_req || oread_req) begin
            hi_cnt++;
        end else begin
            hi_cnt = 0;
            if (rand_lat) ack_lat = $urandom_range(1, 6);
        end
        iwrite_ack = (owrite_req && ack_lat != 0 && hi_cnt >= ack_lat) || inj_wack;
        iread_ack  = oread_req && ack_lat != 0 && hi_cnt >= ack_lat;
        iread_data = rand_data ? DATA_W'($urandom) : rd_word;
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(negedge iclk);
        #1;
    endtask

    task automatic push(input bit we, input int addr, input int data);
        icmd_valid = 1'b1;
        icmd_we    = we;
        icmd_addr  = ADDR_W'(addr);
        icmd_wdata = DATA_W'(data);
        step();
        icmd_valid = 1'b0;
    endtask

    int hi, rv, n, gap, min_gap;
    bit prev_req, first_rise;
    logic [DATA_W-1:0] cap;
    bit iss_we[$];
    int iss_addr[$];

    initial begin
        repeat (3) step();
        chk("rst_ready", ocmd_ready, 1);
        chk("rst_level", olevel, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_reqs", {owrite_req, oread_req, ord_valid}, 0);
        chk("rst_errs", {oerr_timeout, oerr_ack}, 0);
        ireset_n = 1'b1;
        step();

        // single write, ack after 5 cycles
        ack_lat = 5;
        push(1, 'h100, 'h1234);
        hi = 0; rv = 0;
        repeat (20) begin
            if (owrite_req) hi++;
            if (ord_valid) rv++;
            step();
        end
        chk("wr_req_cycles", hi, 5);
        chk("wr_no_rd_valid", rv, 0);

        // single read returning 0x1234
        ack_lat = 3; rd_word = 'h1234;
        push(0, 'h100, 0);
        hi = 0; rv = 0; cap = '0;
        repeat (15) begin
            if (oread_req) hi++;
            if (ord_valid) begin
                rv++;
                cap = ord_data;
                chk("rd_req_low_after_ack", oread_req, 0);
            end
            step();
        end
        chk("rd_req_cycles", hi, 3);
        chk("rd_valid_pulses", rv, 1);
        chk("rd_data_captured", cap, 'h1234);
        chk("rd_data_held", ord_data, 'h1234);

        // fill with stalled controller
        ack_lat = 0;
        for (int i = 0; i < 9; i++) push(i % 2 == 0, i, 'h50 + i);
        chk("full_level", olevel, 8);
        chk("full_ready", ocmd_ready, 0);
        push(0, 'h3ff, 'hdead);
        chk("full_reject_level", olevel, 8);
        chk("full_first_write", owrite_req, 1);
        ack_lat = 2;
        prev_req = 0; first_rise = 1; gap = 0; min_gap = 1000;
        repeat (80) begin
            if ((owrite_req || oread_req) && !prev_req) begin
                iss_we.push_back(owrite_req);
                iss_addr.push_back(int'(owrite_req ? owrite_address : oread_address));
                if (!first_rise && gap < min_gap) min_gap = gap;
                first_rise = 0;
                gap = 0;
            end
            if (!(owrite_req || oread_req)) gap++;
            prev_req = owrite_req || oread_req;
            step();
        end
        chk("issue_count", iss_we.size(), 9);
        for (int i = 0; i < 9 && i < iss_we.size(); i++) begin
            chk("issue_type", iss_we[i], i % 2 == 0);
            chk("issue_addr", iss_addr[i], i);
        end
        chk("min_idle_gap_ge1", min_gap >= 1, 1);

        // simultaneous push and pop at level 3
        ack_lat = 0;
        for (int i = 0; i < 4; i++) push(i % 2 == 0, 'h200 + i, 'h70 + i);
        chk("pp_level_before", olevel, 3);
        ack_lat = 1;
        n = 0;
        do begin step(); n++; end while ((owrite_req || oread_req) && n < 10);
        ack_lat = 0;
        chk("pp_idle_level", olevel, 3);
        push(1, 'h204, 'h74);
        chk("pp_level_after", olevel, 3);
        chk("pp_next_is_read", oread_req, 1);
        chk("pp_next_addr", oread_address, 'h201);
        ack_lat = 2;
        n = 0;
        while (obusy && n < 100) begin step(); n++; end
        chk("pp_drained", obusy, 0);

        // randomized traffic
        rand_lat = 1; rand_data = 1;
        repeat (400) begin
            icmd_valid = ($urandom_range(0, 2) != 0);
            icmd_we    = $urandom_range(0, 1);
            icmd_addr  = ADDR_W'($urandom);
            icmd_wdata = DATA_W'($urandom);
            step();
        end
        icmd_valid = 1'b0;
        n = 0;
        while (obusy && n < 300) begin step(); n++; end
        chk("rand_drained", obusy, 0);
        rand_lat = 0; rand_data = 0;
        step();

        // ack while idle
        chk("err_ack_clear", oerr_ack, 0);
        inj_wack = 1;
        step();
        inj_wack = 0;
        chk("err_ack_idle", oerr_ack, 1);

        // unacknowledged read -> timeout
        ack_lat = 0;
        push(0, 'h1abc, 0);
        n = 0;
        while (!oread_req && n < 5) begin step(); n++; end
        repeat (TIMEOUT - 2) step();
        chk("to_not_yet", oerr_timeout, 0);
        step();
        chk("to_set", oerr_timeout, 1);
        chk("to_req_held", oread_req, 1);

        // async reset while waiting with 2 queued
        push(1, 'h10, 'h11);
        push(0, 'h20, 'h22);
        chk("rst_pre_level", olevel, 2);
        @(posedge iclk);
        #3;
        ireset_n = 1'b0;
        #1;
        chk("arst_reqs", {owrite_req, oread_req}, 0);
        chk("arst_level", olevel, 0);
        chk("arst_busy", obusy, 0);
        chk("arst_errs", {oerr_timeout, oerr_ack}, 0);
        chk("arst_ready", ocmd_ready, 1);
        repeat (2) step();
        ireset_n = 1'b1;
        hi = 0;
        repeat (10) begin
            if (owrite_req || oread_req) hi++;
            step();
        end
        chk("post_rst_no_issue", hi, 0);
        ack_lat = 2;
        push(1, 'h33, 'h44);
        repeat (8) step();
        chk("post_rst_idle", obusy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
